// File: rtl/sh_intc_gen.sv
// sh_intc_gen -- vectored interrupt controller for SH-family cores.
//
// Handles N_SRC maskable sources plus NMI. Each source has a 4-bit priority
// (IPR0-3) and an edge/level mode (EDGE). Pending bits are readable and, for
// edge-mode sources, write-1-to-clear (PEND). The highest-priority pending
// request above INT_MASK is presented to the CPU with a req/ack handshake.
//
// Optional feature macro: SH_INTC_VECREG_EN
//   defined   : VECR0-7 at offsets 0x20-0x3C hold per-source vectors
//   undefined : vectors are fixed at VEC_BASE+i, 0x20-0x3C read 0
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   CE_R, CE_F        rising-phase (state) / falling-phase (read data) enables
//   NMI_N             NMI pin
//   SRC_IRQ[N_SRC]    source requests, active high
//   INT_MASK[4]       CPU SR.I mask
//   INT_REQ/LVL/VEC   presented request, its level and vector
//   INT_ACK           CPU accepts the presented request
//   IBUS_*            register bus: address, write data, read data, byte
//                     enables, write, strobe, window hit, busy (always 0)
module sh_intc_gen #(
    parameter int          N_SRC       = 16,
    parameter logic [27:0] BASE_ADDR   = 28'h5FFFF80,
    parameter logic [7:0]  VEC_BASE    = 8'd64,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE_R,
    input  logic             CE_F,
    input  logic             NMI_N,
    input  logic [N_SRC-1:0] SRC_IRQ,
    input  logic [3:0]       INT_MASK,
    output logic             INT_REQ,
    output logic [3:0]       INT_LVL,
    output logic [7:0]       INT_VEC,
    input  logic             INT_ACK,
    input  logic [27:0]      IBUS_A,
    input  logic [31:0]      IBUS_DI,
    output logic [31:0]      IBUS_DO,
    input  logic [3:0]       IBUS_BA,
    input  logic             IBUS_WE,
    input  logic             IBUS_REQ,
    output logic             IBUS_ACT,
    output logic             IBUS_BUSY
);

    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0][N_SRC-1:0] src_sync;
    logic [SYNC_STAGES-1:0]            nmi_sync;
    logic [N_SRC-1:0] src_next, src_lvl, src_rise;
    logic             nmi_next, nmi_lvl, nmi_set;

    logic [3:0]       prio [N_SRC];
    logic [7:0]       vec_tab [N_SRC];
    logic [N_SRC-1:0] edge_mode, pend, pend_next, pend_w1c, clr_src, be_mask;
    logic             nmie, nmi_pend, clr_nmi;

    logic          win_valid, win_nmi;
    logic [3:0]    win_lvl;
    logic [7:0]    win_vec;
    logic [SW-1:0] win_src;

    logic          cur_nmi, cur_nmi_next;
    logic [SW-1:0] cur_src, cur_src_next;
    logic [3:0]    lvl_next;
    logic [7:0]    vec_next;

    logic [3:0]  word;
    logic        wr_en;
    logic [31:0] rd_data;
    logic        unused_addr;

    // ---------------- bus decode ----------------
    assign IBUS_ACT    = (IBUS_A[27:6] == BASE_ADDR[27:6]);
    assign IBUS_BUSY   = 1'b0;
    assign word        = IBUS_A[5:2];
    assign wr_en       = IBUS_REQ & IBUS_WE & IBUS_ACT;
    assign unused_addr = ^IBUS_A[1:0];

    // ---------------- synchronisers and edge detect ----------------
    // src_next is the value the synchronised level takes on the next CE_R,
    // so edges and level-mode pending update together with the level itself.
    assign src_lvl = src_sync[SYNC_STAGES-1];
    assign nmi_lvl = nmi_sync[SYNC_STAGES-1];

    generate
        if (SYNC_STAGES == 1) begin : g_sync_one
            assign src_next = SRC_IRQ;
            assign nmi_next = NMI_N;
        end else begin : g_sync_many
            assign src_next = src_sync[SYNC_STAGES-2];
            assign nmi_next = nmi_sync[SYNC_STAGES-2];
        end
    endgenerate

    assign src_rise = src_next & ~src_lvl;
    assign nmi_set  = nmie ? (nmi_next & ~nmi_lvl) : (~nmi_next & nmi_lvl);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < N_SRC; i++) be_mask[i] = IBUS_BA[i/8];
    end

    // A new edge is OR-ed in last, so it wins over an ack-clear or W1C.
    assign pend_w1c  = (wr_en && word == 4'd5) ? (IBUS_DI[N_SRC-1:0] & be_mask & edge_mode) : '0;
    assign pend_next = (edge_mode & ((pend & ~(pend_w1c | clr_src)) | src_rise))
                     | (~edge_mode & src_next);

`ifndef SH_INTC_VECREG_EN
    always_comb begin
        for (int i = 0; i < N_SRC; i++) vec_tab[i] = VEC_BASE + 8'(i);
    end
`endif

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments only; blocking
    // assignments stay inside always_comb.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_sync  <= '0;
            nmi_sync  <= '0;
            edge_mode <= '0;
            pend      <= '0;
            nmie      <= 1'b0;
            nmi_pend  <= 1'b0;
            // NOTE: the priority file is reset entry by entry because IPR=0
            // is what keeps every source masked after reset.
            for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
`ifdef SH_INTC_VECREG_EN
            for (int i = 0; i < N_SRC; i++) vec_tab[i] <= VEC_BASE + 8'(i);
`endif
        end else if (CE_R) begin
            src_sync[0] <= SRC_IRQ;
            nmi_sync[0] <= NMI_N;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                src_sync[k] <= src_sync[k-1];
                nmi_sync[k] <= nmi_sync[k-1];
            end
            pend     <= pend_next;
            nmi_pend <= (nmi_pend & ~clr_nmi) | nmi_set;
            if (wr_en) begin
                for (int i = 0; i < N_SRC; i++)
                    if (word == 4'(i/8) && IBUS_BA[(i%8)/2])
                        prio[i] <= IBUS_DI[4*(i%8) +: 4];
                if (word == 4'd4)
                    edge_mode <= (edge_mode & ~be_mask) | (IBUS_DI[N_SRC-1:0] & be_mask);
                if (word == 4'd6 && IBUS_BA[0])
                    nmie <= IBUS_DI[0];
`ifdef SH_INTC_VECREG_EN
                for (int i = 0; i < N_SRC; i++)
                    if (word == 4'(8 + i/4) && IBUS_BA[i%4])
                        vec_tab[i] <= IBUS_DI[8*(i%4) +: 8];
`endif
            end
        end
    end

    // ---------------- arbitration ----------------
    // Strict '>' while scanning upward keeps the lowest index on a tie;
    // starting from INT_MASK enforces IPR > mask.
    always_comb begin
        win_valid = 1'b0;
        win_nmi   = 1'b0;
        win_lvl   = INT_MASK;
        win_vec   = '0;
        win_src   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pend[i] && prio[i] > win_lvl) begin
                win_valid = 1'b1;
                win_lvl   = prio[i];
                win_vec   = vec_tab[i];
                win_src   = SW'(i);
            end
        end
        if (nmi_pend) begin
            win_valid = 1'b1;
            win_nmi   = 1'b1;
            win_lvl   = 4'd15;
            win_vec   = 8'd11;
            win_src   = '0;
        end
    end

    // ---------------- request FSM ----------------
    always_comb begin
        state_next   = state;
        lvl_next     = INT_LVL;
        vec_next     = INT_VEC;
        cur_nmi_next = cur_nmi;
        cur_src_next = cur_src;
        clr_nmi      = 1'b0;
        clr_src      = '0;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    lvl_next     = win_lvl;
                    vec_next     = win_vec;
                    cur_nmi_next = win_nmi;
                    cur_src_next = win_src;
                    state_next   = S_REQ;
                end
            end
            S_REQ: begin
                if (INT_ACK) begin
                    if (cur_nmi) clr_nmi = 1'b1;
                    else         clr_src[cur_src] = 1'b1;
                    state_next = S_HOLD;
                end else if (win_valid) begin
                    // Re-latch follows any change of winner without dropping INT_REQ.
                    lvl_next     = win_lvl;
                    vec_next     = win_vec;
                    cur_nmi_next = win_nmi;
                    cur_src_next = win_src;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HOLD:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            INT_LVL <= '0;
            INT_VEC <= '0;
            cur_nmi <= 1'b0;
            cur_src <= '0;
        end else if (CE_R) begin
            state   <= state_next;
            INT_LVL <= lvl_next;
            INT_VEC <= vec_next;
            cur_nmi <= cur_nmi_next;
            cur_src <= cur_src_next;
        end
    end

    assign INT_REQ = (state == S_REQ);

    // ---------------- read path ----------------
    always_comb begin
        rd_data = '0;
        case (word)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                for (int i = 0; i < N_SRC; i++)
                    if (word == 4'(i/8)) rd_data[4*(i%8) +: 4] = prio[i];
            end
            4'd4: rd_data[N_SRC-1:0] = edge_mode;
            4'd5: rd_data[N_SRC-1:0] = pend;
            4'd6: rd_data[1:0]       = {nmi_lvl, nmie};
            default: begin
`ifdef SH_INTC_VECREG_EN
                for (int i = 0; i < N_SRC; i++)
                    if (word == 4'(8 + i/4)) rd_data[8*(i%4) +: 8] = vec_tab[i];
`endif
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            IBUS_DO <= '0;
        else if (CE_F && IBUS_REQ && !IBUS_WE && IBUS_ACT)
            IBUS_DO <= rd_data;
    end

endmodule

// File: tb/tb_sh_intc_gen.sv
// Directed testbench for sh_intc_gen (default parameters).
// Inputs change 1 time unit after a rising clock edge; outputs are sampled
// at the same point, away from the active edge.
module tb_sh_intc_gen;

    localparam logic [27:0] BASE = 28'h5FFFF80;

    logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b1, CE_F = 1'b1, NMI_N = 1'b1;
    logic [15:0] SRC_IRQ = '0;
    logic [3:0]  INT_MASK = '0;
    logic        INT_REQ, INT_ACK = 1'b0;
    logic [3:0]  INT_LVL;
    logic [7:0]  INT_VEC;
    logic [27:0] IBUS_A = BASE;
    logic [31:0] IBUS_DI = '0, IBUS_DO;
    logic [3:0]  IBUS_BA = '0;
    logic        IBUS_WE = 1'b0, IBUS_REQ = 1'b0, IBUS_ACT, IBUS_BUSY;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd;

    sh_intc_gen dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .NMI_N(NMI_N),
        .SRC_IRQ(SRC_IRQ), .INT_MASK(INT_MASK), .INT_REQ(INT_REQ),
        .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_ACK(INT_ACK),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_ACT(IBUS_ACT),
        .IBUS_BUSY(IBUS_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] off, input logic [31:0] d, input logic [3:0] ba);
        IBUS_A   = BASE + 28'(off);
        IBUS_DI  = d;
        IBUS_BA  = ba;
        IBUS_WE  = 1'b1;
        IBUS_REQ = 1'b1;
        tick(1);
        IBUS_REQ = 1'b0;
        IBUS_WE  = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] off, output logic [31:0] d);
        IBUS_A   = BASE + 28'(off);
        IBUS_WE  = 1'b0;
        IBUS_REQ = 1'b1;
        tick(1);
        d = IBUS_DO;
        IBUS_REQ = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        tick(2);
        check("rst_int_req", 32'(INT_REQ), 32'd0);
        check("rst_int_lvl", 32'(INT_LVL), 32'd0);
        check("rst_int_vec", 32'(INT_VEC), 32'd0);
        check("rst_ibus_do", IBUS_DO, 32'd0);
        RST_N = 1'b1;
        tick(1);
        check("busy_zero", 32'(IBUS_BUSY), 32'd0);
        check("act_in_window", 32'(IBUS_ACT), 32'd1);
        IBUS_A = BASE + 28'd64;
        #1;
        check("act_out_window", 32'(IBUS_ACT), 32'd0);
        bus_read(6'h00, rd);  check("rst_ipr0", rd, 32'd0);
        bus_read(6'h14, rd);  check("rst_pend", rd, 32'd0);

        // ---- register map boundaries ----
        bus_write(6'h04, 32'h1234_5678, 4'b0100);
        bus_read(6'h04, rd);  check("ipr1_byte_enable", rd, 32'h0034_0000);
        bus_write(6'h08, 32'hFFFF_FFFF, 4'b1111);
        bus_read(6'h08, rd);  check("ipr2_absent_srcs", rd, 32'd0);
        bus_read(6'h1C, rd);  check("unused_offset", rd, 32'd0);

        // ---- single edge source 3, IPR=5 ----
        bus_write(6'h00, 32'h0000_5000, 4'b0010);
        bus_write(6'h10, 32'h0000_0008, 4'b0001);
        SRC_IRQ = 16'h0008;
        tick(1);
        SRC_IRQ = '0;
        tick(1);
        check("t1_req_not_yet", 32'(INT_REQ), 32'd0);
        tick(1);
        check("t1_req", 32'(INT_REQ), 32'd1);
        check("t1_lvl", 32'(INT_LVL), 32'd5);
        check("t1_vec", 32'(INT_VEC), 32'd67);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        check("t1_req_after_ack", 32'(INT_REQ), 32'd0);
        bus_read(6'h14, rd);  check("t1_pend_cleared", rd, 32'd0);

        // ---- tie: sources 2 and 7 at IPR=9 ----
        bus_write(6'h00, 32'h9000_0900, 4'b1111);
        bus_write(6'h10, 32'h0000_0084, 4'b0001);
        SRC_IRQ = 16'h0084;
        tick(1);
        SRC_IRQ = '0;
        tick(2);
        check("t2_req", 32'(INT_REQ), 32'd1);
        check("t2_vec_first", 32'(INT_VEC), 32'd66);
        check("t2_lvl_first", 32'(INT_LVL), 32'd9);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        check("t2_req_drop", 32'(INT_REQ), 32'd0);
        tick(1);
        check("t2_hold_gap", 32'(INT_REQ), 32'd0);
        tick(1);
        check("t2_req_second", 32'(INT_REQ), 32'd1);
        check("t2_vec_second", 32'(INT_VEC), 32'd71);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        tick(2);

        // ---- pre-emption: source 1 IPR=4, then source 5 IPR=12 ----
        bus_write(6'h00, 32'h00C0_0040, 4'b1111);
        bus_write(6'h10, 32'h0000_0022, 4'b0001);
        SRC_IRQ = 16'h0002;
        tick(1);
        SRC_IRQ = '0;
        tick(2);
        check("t3_vec_low", 32'(INT_VEC), 32'd65);
        SRC_IRQ = 16'h0020;
        tick(1);
        SRC_IRQ = '0;
        tick(1);
        check("t3_lvl_before", 32'(INT_LVL), 32'd4);
        tick(1);
        check("t3_req_kept", 32'(INT_REQ), 32'd1);
        check("t3_lvl_relatch", 32'(INT_LVL), 32'd12);
        check("t3_vec_relatch", 32'(INT_VEC), 32'd69);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        tick(2);
        check("t3_low_again", 32'(INT_VEC), 32'd65);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        tick(1);

        // ---- level source 0, IPR=3 against mask ----
        bus_write(6'h00, 32'h0000_0003, 4'b1111);
        bus_write(6'h10, 32'h0000_0000, 4'b1111);
        INT_MASK = 4'd3;
        SRC_IRQ  = 16'h0001;
        tick(4);
        check("t4_masked", 32'(INT_REQ), 32'd0);
        bus_read(6'h14, rd);  check("t4_level_pend", rd, 32'h1);
        INT_MASK = 4'd2;
        tick(1);
        check("t4_unmasked_req", 32'(INT_REQ), 32'd1);
        check("t4_vec", 32'(INT_VEC), 32'd64);
        SRC_IRQ = '0;
        tick(2);
        check("t4_req_still", 32'(INT_REQ), 32'd1);
        tick(1);
        check("t4_withdrawn", 32'(INT_REQ), 32'd0);
        INT_MASK = 4'd0;

        // ---- NMI on rising pin edge while source 4 is presented ----
        bus_write(6'h00, 32'h0006_0000, 4'b1111);
        bus_write(6'h10, 32'h0000_0010, 4'b0001);
        bus_write(6'h18, 32'h0000_0001, 4'b0001);
        NMI_N = 1'b0;
        tick(3);
        check("t5_falling_ignored", 32'(INT_REQ), 32'd0);
        SRC_IRQ = 16'h0010;
        tick(1);
        SRC_IRQ = '0;
        tick(2);
        check("t5_src4_vec", 32'(INT_VEC), 32'd68);
        NMI_N = 1'b1;
        tick(3);
        check("t5_nmi_req", 32'(INT_REQ), 32'd1);
        check("t5_nmi_lvl", 32'(INT_LVL), 32'd15);
        check("t5_nmi_vec", 32'(INT_VEC), 32'd11);
        bus_read(6'h18, rd);  check("t5_icr", rd, 32'h3);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        tick(2);
        check("t5_src4_after_nmi", 32'(INT_VEC), 32'd68);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        tick(1);

        // ---- W1C on the same CE_R as a new edge ----
        INT_MASK = 4'd15;
        SRC_IRQ  = 16'h0010;
        tick(1);
        SRC_IRQ = '0;
        bus_write(6'h14, 32'h0000_0010, 4'b1111);
        bus_read(6'h14, rd);  check("t5_set_beats_w1c", rd, 32'h10);
        bus_write(6'h14, 32'h0000_0010, 4'b1111);
        bus_read(6'h14, rd);  check("t5_w1c_clears", rd, 32'h0);
        INT_MASK = 4'd0;

        // ---- reset in the middle of a request ----
        SRC_IRQ = 16'h0010;
        tick(1);
        SRC_IRQ = '0;
        tick(2);
        check("t6_req_before_rst", 32'(INT_REQ), 32'd1);
        RST_N = 1'b0;
        #2;
        check("t6_rst_req", 32'(INT_REQ), 32'd0);
        check("t6_rst_lvl", 32'(INT_LVL), 32'd0);
        check("t6_rst_vec", 32'(INT_VEC), 32'd0);
        RST_N = 1'b1;
        tick(1);
        bus_read(6'h00, rd);  check("t6_ipr0", rd, 32'd0);
        bus_read(6'h10, rd);  check("t6_edge", rd, 32'd0);
        bus_read(6'h14, rd);  check("t6_pend", rd, 32'd0);
        bus_read(6'h20, rd);
`ifdef SH_INTC_VECREG_EN
        check("t6_vecr0", rd, 32'h4342_4140);
`else
        check("t6_vecr0_absent", rd, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
